// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared single-precision types, constants, leading-zero count
//               helper and the accumulator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam int          FP32_MANT_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ADD  = 2'd2,
        ST_OUT  = 2'd3
    } acc_state_e;

    // Number of zeros above the most significant set bit; 24 for an all-zero input.
    function automatic logic [4:0] lzc24(input logic [FP32_MANT_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = FP32_MANT_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(FP32_MANT_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_dot_accumulator_add_norm.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_norm
// Description : Combinational align / add / normalise core. i_a is the running
//               sum, i_b the incoming operand. Truncating, no NaN handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_norm
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    fp32_t                   w_a;
    fp32_t                   w_b;
    fp32_t                   w_big;
    fp32_t                   w_small;
    logic [7:0]              w_diff;
    logic [FP32_MANT_W-1:0]  w_big_mant;
    logic [FP32_MANT_W-1:0]  w_small_mant;
    logic [FP32_MANT_W:0]    w_raw;
    logic [4:0]              w_lz;
    logic signed [9:0]       w_exp;
    logic [FP32_MANT_W-1:0]  w_mant;

    assign w_a = i_a;
    assign w_b = i_b;

    // Order operands by magnitude, align, add/subtract, normalise and saturate.
    always_comb begin
        w_big   = w_a;
        w_small = w_b;
        if ({w_b.exp, w_b.frac} > {w_a.exp, w_a.frac}) begin
            w_big   = w_b;
            w_small = w_a;
        end
        w_diff       = w_big.exp - w_small.exp;
        w_big_mant   = {1'b1, w_big.frac};
        w_small_mant = (w_diff >= 8'd24) ? '0 : ({1'b1, w_small.frac} >> w_diff);
        if (w_big.sign == w_small.sign)
            w_raw = {1'b0, w_big_mant} + {1'b0, w_small_mant};
        else
            w_raw = {1'b0, w_big_mant} - {1'b0, w_small_mant};
        w_lz  = lzc24(w_raw[FP32_MANT_W-1:0]);
        w_exp = $signed({2'b00, w_big.exp});
        if (w_raw[FP32_MANT_W]) begin
            w_mant = w_raw[FP32_MANT_W:1];
            w_exp  = w_exp + 10'sd1;
        end else begin
            // An all-zero mantissa stays zero, so bit 23 also flags cancellation.
            w_mant = w_raw[FP32_MANT_W-1:0] << w_lz;
            w_exp  = w_exp - $signed({5'b00000, w_lz});
        end

        if (w_a.exp == FP32_EXP_MAX)
            o_sum = i_a;                         // infinity is sticky
        else if (w_b.exp == 8'd0)
            o_sum = i_a;                         // zero operand leaves the sum
        else if (i_a == FP32_ZERO)
            o_sum = i_b;                         // +0 sum loads the operand
        else if (!w_mant[FP32_MANT_W-1])
            o_sum = FP32_ZERO;                   // exact cancellation
        else if (w_exp <= 10'sd0)
            o_sum = FP32_ZERO;                   // underflow flushes to +0
        else if (w_exp >= 10'sd255)
            o_sum = {w_big.sign, FP32_EXP_MAX, 23'd0};
        else
            o_sum = {w_big.sign, w_exp[7:0], w_mant[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fp_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp_dot_accumulator
// Description : Streaming fp32 frame accumulator with valid/ready on both
//               sides. One term per two cycles after the first of a frame.
//               Optional macro FP_DOT_ACC_RELU_EN fuses a ReLU at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_dot_accumulator
    import fp32_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int SKIP_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] term_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_e       r_state;
    fp32_t            r_sum;
    fp32_t            r_op;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_data;

    logic             w_accept;
    logic [31:0]      w_load;
    logic [31:0]      w_core_b;
    logic [31:0]      w_core_sum;
    logic [31:0]      w_add_sum;

    // Value presented downstream for a given internal sum.
    function automatic logic [31:0] f_out(input logic [31:0] s);
`ifdef FP_DOT_ACC_RELU_EN
        return s[31] ? FP32_ZERO : s;
`else
        return s;
`endif
    endfunction

    assign w_accept = in_valid && r_in_ready;
    assign w_load   = (in_data[30:23] == 8'd0) ? FP32_ZERO : in_data;

    if (SKIP_ZERO != 0) begin : g_skip_zero
        assign w_core_b  = r_op;
        assign w_add_sum = (r_op.exp == 8'd0) ? r_sum : w_core_sum;
    end else begin : g_flush_zero
        assign w_core_b  = (r_op.exp == 8'd0) ? FP32_ZERO : r_op;
        assign w_add_sum = w_core_sum;
    end

    fp_add_norm u_add_norm (
        .i_a   (r_sum),
        .i_b   (w_core_b),
        .o_sum (w_core_sum)
    );

    // Frame FSM: load first term, alternate accept/add, hold result until taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= FP32_ZERO;
            r_op        <= FP32_ZERO;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= FP32_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_sum <= w_load;
                        r_cnt <= c_CNT_ONE;
                        if (in_last) begin
                            r_state     <= ST_OUT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= f_out(w_load);
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_op       <= in_data;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ADD;
                        if (r_cnt != c_CNT_MAX)
                            r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_ADD: begin
                    r_sum <= w_add_sum;
                    if (r_last) begin
                        r_state     <= ST_OUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= f_out(w_add_sum);
                    end else begin
                        r_state    <= ST_ACC;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_sum       <= FP32_ZERO;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign term_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_dot_accumulator
// Description : Self-checking bench for fp_dot_accumulator: directed frames
//               with literal results plus random frames against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_dot_accumulator;

    localparam int CNT_W = 3;
    localparam int CMAX  = 7;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b1;
    logic [31:0]      in_data   = 32'h0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] term_cnt;

    int total   = 0;
    int bad     = 0;
    int or_mode = 0;
    bit chk_en  = 1'b0;

    // model state
    bit          m_ready   = 1'b0;
    bit          m_valid   = 1'b0;
    bit          m_first   = 1'b1;
    bit          m_add_due = 1'b0;
    bit          m_op_last = 1'b0;
    logic [31:0] m_sum     = 32'h0;
    logic [31:0] m_data    = 32'h0;
    logic [31:0] m_op      = 32'h0;
    int          m_cnt     = 0;

    fp_dot_accumulator #(.CNT_W(CNT_W), .SKIP_ZERO(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .term_cnt  (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference add: exact integer mantissas, truncating pre-shift of the smaller operand.
    function automatic logic [31:0] model_add(input logic [31:0] s, input logic [31:0] t);
        logic [31:0] big, sml;
        longint      mb, ms, r;
        int          e, d;
        if (s[30:23] == 8'hFF) return s;
        if (t[30:23] == 8'h00) return s;
        if (s == 32'h0) return t;
        if (t[30:0] > s[30:0]) begin big = t; sml = s; end
        else begin big = s; sml = t; end
        d  = int'(big[30:23]) - int'(sml[30:23]);
        mb = 64'h80_0000 | 64'(big[22:0]);
        ms = (d >= 24) ? 64'd0 : ((64'h80_0000 | 64'(sml[22:0])) >> d);
        r  = (big[31] == sml[31]) ? mb + ms : mb - ms;
        if (r == 0) return 32'h0;
        e = int'(big[30:23]);
        while (r >= 64'h100_0000) begin r = r >> 1; e++; end
        while (r < 64'h80_0000) begin r = r << 1; e--; end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {big[31], 8'hFF, 23'h0};
        return {big[31], e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] model_out(input logic [31:0] s);
`ifdef FP_DOT_ACC_RELU_EN
        return s[31] ? 32'h0 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] rand_term();
        int          k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        if (k == 0)      v[30:23] = 8'h00;
        else if (k == 1) v = 32'h0;
        else if (k == 2) v[30:23] = 8'(253 + $urandom_range(0, 1));
        else             v[30:23] = 8'(124 + $urandom_range(0, 7));
        return v;
    endfunction

    // Behavioural model: timing rules of the handshake plus frame arithmetic.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_ready = 1'b0; m_valid = 1'b0; m_first = 1'b1; m_add_due = 1'b0;
            m_sum = 32'h0; m_data = 32'h0; m_cnt = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0; m_ready = 1'b1; m_sum = 32'h0; m_first = 1'b1;
            end
        end else if (m_add_due) begin
            m_add_due = 1'b0;
            m_sum = model_add(m_sum, m_op);
            if (m_op_last) begin
                m_valid = 1'b1; m_data = model_out(m_sum); m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (in_valid) begin
            if (m_first) begin
                m_sum   = (in_data[30:23] == 8'h00) ? 32'h0 : in_data;
                m_cnt   = 1;
                m_first = 1'b0;
                if (in_last) begin
                    m_valid = 1'b1; m_data = model_out(m_sum); m_ready = 1'b0;
                end
            end else begin
                m_op = in_data; m_op_last = in_last; m_add_due = 1'b1; m_ready = 1'b0;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("term_cnt", 32'(term_cnt), m_cnt);
            if (m_valid) chk("out_data", out_data, m_data);
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!ok && guard < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_out(input string nm, input logic [31:0] ed, input int ec, input int elat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_cnt"}, 32'(term_cnt), ec);
        chk({nm, "_lat"}, n, elat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // model pins
        chk("pin_1p2", model_add(32'h3F800000, 32'h40000000), 32'h40400000);
        chk("pin_3p05", model_add(32'h40400000, 32'h3F000000), 32'h40600000);
        chk("pin_cancel", model_add(32'h3F800000, 32'hBF800000), 32'h00000000);
        chk("pin_diff24", model_add(32'h3F800000, 32'h33800000), 32'h3F800000);
        chk("pin_diff23", model_add(32'h3F800000, 32'h34000000), 32'h3F800001);
        chk("pin_ovf", model_add(32'h7F000000, 32'h7F000000), 32'h7F800000);
        chk("pin_unf", model_add(32'h00800000, 32'h80C00000), 32'h00000000);
        chk("pin_ident", model_add(32'h00000000, 32'hC0400000), 32'hC0400000);
        chk("pin_zero", model_add(32'h3F800000, 32'h80000123), 32'h3F800000);
        chk("pin_norm", model_add(32'h40000000, 32'hBF800000), 32'h3F800000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_term_cnt", 32'(term_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // three-term frame
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F000000, 1'b1);
        wait_out("t1", 32'h40600000, 3, 2);

        // cancellation
        send(32'h3F800000, 1'b0);
        send(32'hBF800000, 1'b1);
        wait_out("t2", 32'h00000000, 2, 2);

        // negative result / ReLU
        send(32'h3F800000, 1'b0);
        send(32'hC0400000, 1'b1);
`ifdef FP_DOT_ACC_RELU_EN
        wait_out("t3", 32'h00000000, 2, 2);
`else
        wait_out("t3", 32'hC0000000, 2, 2);
`endif

        // single-term frame
        send(32'h41200000, 1'b1);
        wait_out("t5", 32'h41200000, 1, 1);

        // overflow to infinity, which then sticks
        send(32'h7F000000, 1'b0);
        send(32'h7F000000, 1'b0);
        send(32'hBF800000, 1'b1);
        wait_out("inf", 32'h7F800000, 3, 2);

        // backpressure
        or_mode = 2;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); n++; end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 32'h41200000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", out_data, 32'h40400000);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        or_mode = 0;
        send(32'h41200000, 1'b1);
        wait_out("bp_next", 32'h41200000, 1, 1);

        // reset mid-frame
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_data", out_data, 32'h0);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        chk("mr_term_cnt", 32'(term_cnt), 32'd0);
        @(posedge clk);
        #1;
        send(32'h40400000, 1'b0);
        send(32'h40400000, 1'b1);
        wait_out("t6", 32'h40C00000, 2, 2);
        send(32'h40400000, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h40400000, 1'b1);
        wait_out("t6_zero", 32'h40C00000, 3, 2);

        // random frames, random backpressure, counter saturation
        or_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(rand_term(), (i == len - 1));
            end
        end
        or_mode = 0;
        repeat (30) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
